// File: rtl/spi_xbar_arbiter_if.sv
// Host-side handshake and crossbar routing bundle for the SD slot arbiter.
interface spi_xbar_arbiter_if;
    logic [1:0] mcu_req_i;
    logic [1:0] fpga_req_i;
    logic       mcu_ssel_i;
    logic       fpga_ssel_i;
    logic [1:0] mcu_gnt_o;
    logic [1:0] fpga_gnt_o;
    logic [7:0] config_o;
    logic [1:0] fpga_sel_o;
    logic       timeout_o;

    modport master (
        output mcu_req_i, fpga_req_i, mcu_ssel_i, fpga_ssel_i,
        input  mcu_gnt_o, fpga_gnt_o, config_o, fpga_sel_o, timeout_o
    );

    modport slave (
        input  mcu_req_i, fpga_req_i, mcu_ssel_i, fpga_ssel_i,
        output mcu_gnt_o, fpga_gnt_o, config_o, fpga_sel_o, timeout_o
    );
endinterface

// File: rtl/spi_xbar_arbiter.sv
// Shares SD0/SD1 between MCU and FPGA SPI hosts; drives crossbar routing so
// it only changes on idle buses, with guard time and idle-owner revocation.
module spi_xbar_arbiter #(
    parameter int GUARD_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic               clk_i,
    input  logic               n_rst_i,
    spi_xbar_arbiter_if.slave  bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_GUARD, S_GRANT, S_DRAIN} st_t;

    st_t             st   [2];
    st_t             st_n [2];
    logic [GW-1:0]   gcnt   [2];
    logic [GW-1:0]   gcnt_n [2];
    logic [TW-1:0]   tcnt   [2];
    logic [TW-1:0]   tcnt_n [2];
    logic [1:0]      own, own_n, ptr, ptr_n;
    logic [1:0]      msel, msel_n, fsel, fsel_n;
    logic            to_q, to_n;
    logic [1:0]      msync, fsync;
    logic            mss, fss;
    logic [1:0]      em, ef, win, oss, oreq, comp, rel;
    logic            cm, cf;
    logic [1:0]      mg, fg;

    // chip selects idle high, so synchronisers reset to deasserted
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            msync <= 2'b11;
            fsync <= 2'b11;
        end else begin
            msync <= {msync[0], bus.mcu_ssel_i};
            fsync <= {fsync[0], bus.fpga_ssel_i};
        end
    end
    assign mss = msync[1];
    assign fss = fsync[1];

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            for (int s = 0; s < 2; s++) begin
                st[s]   <= S_IDLE;
                gcnt[s] <= '0;
                tcnt[s] <= '0;
            end
            own  <= 2'b00;
            ptr  <= 2'b11;
            msel <= 2'b11;
            fsel <= 2'b11;
            to_q <= 1'b0;
        end else begin
            st   <= st_n;
            gcnt <= gcnt_n;
            tcnt <= tcnt_n;
            own  <= own_n;
            ptr  <= ptr_n;
            msel <= msel_n;
            fsel <= fsel_n;
            to_q <= to_n;
        end
    end

    always_comb begin
        st_n   = st;
        gcnt_n = gcnt;
        tcnt_n = tcnt;
        own_n  = own;
        ptr_n  = ptr;
        msel_n = msel;
        fsel_n = fsel;
        to_n   = 1'b0;
        em = '0; ef = '0; win = '0; oss = '0; oreq = '0; comp = '0; rel = '0;
        cm = 1'b0;
        cf = 1'b0;
        for (int s = 0; s < 2; s++) begin
            // a host busy on the other slot, or just picked by SD0, is ineligible
            em[s]   = bus.mcu_req_i[s]  & ~((st[1-s] != S_IDLE) & ~own[1-s]) & ~cm;
            ef[s]   = bus.fpga_req_i[s] & ~((st[1-s] != S_IDLE) &  own[1-s]) & ~cf;
            oss[s]  = own[s] ? fss : mss;
            oreq[s] = own[s] ? bus.fpga_req_i[s] : bus.mcu_req_i[s];
            comp[s] = own[s] ? em[s] : ef[s];
            win[s]  = (em[s] & ef[s]) ? ~ptr[s] : ef[s];
            case (st[s])
                S_IDLE: if (em[s] | ef[s]) begin
                    st_n[s]   = S_GUARD;
                    own_n[s]  = win[s];
                    ptr_n[s]  = win[s];
                    gcnt_n[s] = '0;
                    if (win[s]) begin
                        fsel_n = 2'(s);
                        cf     = 1'b1;
                    end else begin
                        msel_n = 2'(s);
                        cm     = 1'b1;
                    end
                end
                S_GUARD: begin
                    if (gcnt[s] == GW'(GUARD_CYCLES - 1)) begin
                        st_n[s]   = S_GRANT;
                        tcnt_n[s] = '0;
                    end else begin
                        gcnt_n[s] = gcnt[s] + GW'(1);
                    end
                end
                S_GRANT: begin
                    if (!oreq[s]) begin
                        tcnt_n[s] = '0;
                        if (oss[s]) begin
                            st_n[s] = S_IDLE;
                            rel[s]  = 1'b1;
                        end else begin
                            st_n[s] = S_DRAIN;
                        end
                    end else if (comp[s] & oss[s]) begin
                        // pointer already names the owner, so the waiter wins next
                        if (tcnt[s] == TW'(TIMEOUT_CYCLES - 1)) begin
                            st_n[s]   = S_IDLE;
                            rel[s]    = 1'b1;
                            to_n      = 1'b1;
                            tcnt_n[s] = '0;
                        end else begin
                            tcnt_n[s] = tcnt[s] + TW'(1);
                        end
                    end else begin
                        tcnt_n[s] = '0;
                    end
                end
                S_DRAIN: if (oss[s]) begin
                    st_n[s] = S_IDLE;
                    rel[s]  = 1'b1;
                end
                default: st_n[s] = S_IDLE;
            endcase
            if (rel[s]) begin
                if (own[s]) fsel_n = 2'b11;
                else        msel_n = 2'b11;
            end
        end
    end

    always_comb begin
        mg = '0;
        fg = '0;
        for (int s = 0; s < 2; s++) begin
            mg[s] = (st[s] == S_GRANT) & ~own[s];
            fg[s] = (st[s] == S_GRANT) &  own[s];
        end
    end

    assign bus.mcu_gnt_o  = mg;
    assign bus.fpga_gnt_o = fg;
    assign bus.config_o   = {2'b00, msel, 2'b00, own[1], own[0]};
    assign bus.fpga_sel_o = fsel;
    assign bus.timeout_o  = to_q;
endmodule

// File: doc/spi_xbar_arbiter.md
Name: spi_xbar_arbiter

Overview:
Clocked arbiter that shares the two SD card slots between the two SPI hosts, the MCU and the FPGA master port. It sits beside the SPI crossbar and owns its routing. It drives an 8-bit word in the crossbar config layout, plus the 2-bit FPGA slave select, so routing only changes while the affected bus is idle. Hosts use a level request/grant handshake per slot, with guard time on switch-over and forced revocation of idle owners.

Parameters:
GUARD_CYCLES, 4, cycles between a routing change and grant assertion; minimum 1.
TIMEOUT_CYCLES, 65535, idle-owner cycles tolerated while the other host waits; minimum 2.
TW, $clog2(TIMEOUT_CYCLES+1), timeout counter width (derived).

Ports:
clk_i  in  1  system clock.
n_rst_i  in  1  reset, asynchronous, active-low.
mcu_req_i  in  2  MCU request per slot, [0]=SD0, [1]=SD1; level, synchronous to clk_i.
fpga_req_i  in  2  FPGA request per slot; level, synchronous to clk_i.
mcu_ssel_i  in  1  MCU SPI chip select, active-low, asynchronous.
fpga_ssel_i  in  1  FPGA master SPI chip select, active-low, asynchronous.
mcu_gnt_o  out  2  MCU grant per slot.
fpga_gnt_o  out  2  FPGA grant per slot.
config_o  out  8  crossbar config word: [0]=SD0 owner, [1]=SD1 owner (0=MCU, 1=FPGA), [5:4]=MCU slave select (00=SD0, 01=SD1, 11=none); all other bits 0.
fpga_sel_o  out  2  FPGA slave select: 00=SD0, 01=SD1, 11=none.
timeout_o  out  1  one-cycle pulse on any forced revocation.

Behaviour:
- Reset values: all grants 0, config_o=8'h30, fpga_sel_o=2'b11, timeout_o=0, all slot FSMs IDLE, each slot's round-robin pointer = FPGA (so MCU wins the first tie).
- Reset mid-operation: asynchronous return to the reset values; no pending state survives.
- Synchronisation: mcu_ssel_i and fpga_ssel_i pass through 2-flop synchronisers; all FSM logic uses the synced versions (2-cycle latency).
- Two identical per-slot FSMs: IDLE, GUARD, GRANTED, DRAIN.
- One grant per host: a host may hold at most one grant at a time.
  - Requests from a host that already holds a grant on the other slot are ignored.
  - If both slots would grant the same host in the same cycle, SD0 wins and SD1 waits.
- IDLE:
  - Requesters = eligible req bits for the slot.
  - One requester: it wins. Both requesting: the host not pointed to by the round-robin pointer wins.
  - Next cycle: enter GUARD, update the owner bit and the winner's select field in config_o/fpga_sel_o, and set the pointer to the winner.
  - Select fields otherwise keep their previous value while IDLE. A loser's field never points at this slot.
- GUARD: count GUARD_CYCLES cycles with no grant, then GRANTED. Grant rises GUARD_CYCLES+1 cycles after the request is first sampled.
- GRANTED: owner's gnt=1.
  - Owner drops req with synced ssel high: gnt falls next cycle, go IDLE, owner's select field returns to none (11).
  - Owner drops req with synced ssel low: go DRAIN with gnt=0; stay until synced ssel is high, then IDLE as above.
- Timeout counter (TW bits):
  - Increments while GRANTED, the other host requests this slot, and the owner's synced ssel is high.
  - Clears on synced ssel low, when the competing request is absent, or on leaving GRANTED.
  - On reaching TIMEOUT_CYCLES: gnt falls, timeout_o pulses for 1 cycle, go IDLE. The pointer makes the waiting host win the next arbitration even if the old owner still requests.
- Simultaneous events: owner release in the same cycle the timeout is reached counts as a normal release, with no timeout_o pulse. A new request arriving in the release cycle is arbitrated in the following IDLE cycle.
- Requests changing during GUARD: no effect; the grant still completes, and the host must release it normally.

Test Plan:
- Single request: after reset, mcu_req_i=01 at cycle 0 -> config_o=8'h00 at cycle 1, mcu_gnt_o=01 at cycle 5 (GUARD_CYCLES=4).
- Tie: mcu_req_i=01 and fpga_req_i=01 together -> MCU granted. After MCU releases -> FPGA granted with config_o[0]=1, fpga_sel_o=00, config_o[5:4]=11.
- Drain: MCU owns SD1, drops mcu_req_i[1] while mcu_ssel_i=0 -> gnt 0, state DRAIN, config_o unchanged. Raise ssel -> IDLE 3 cycles later, config_o[5:4]=11.
- Timeout: TIMEOUT_CYCLES=8, FPGA owns SD0 idle, MCU requests SD0 -> timeout_o pulses 8 cycles later. MCU is granted GUARD_CYCLES+1 cycles after that, despite FPGA still requesting.
- One grant per host: MCU owns SD0 and requests SD1 while FPGA requests SD1 -> SD1 goes to FPGA; mcu_gnt_o never shows 11.
- Reset mid-GUARD: assert n_rst_i low -> outputs immediately return to config_o=8'h30, fpga_sel_o=11, all grants 0.
